emern_load_window_ctrl: RTL and testbench
=========================================

Name: emern_load_window_ctrl

Overview:
- Schedules when the SPI frontend may update the rasterizer's registers.
- Opens a load window only during vertical/horizontal blanking (screen_inactive) on every (cfg_div+1)-th blanking interval.
- Signals the host through the INT pin, tracks SPI transactions within the window, and flags transfers that overrun into active video.
- Sits between the VGA timing generator, the frontend's en_load input and the uio INT output.

Parameters:
- FRAME_CNT_W, 8, width of frame counter output.
- INT_PULSE_LEN, 4, INT pulse length in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  async active-low reset
- screen_inactive_in  input  1  high outside visible area; synchronous to clk
- cs_in  input  1  raw SPI chip select (active low) from uio_in[0]; asynchronous
- cfg_div  input  2  window divider; window opens every cfg_div+1 blanking intervals
- clr_ovr  input  1  synchronous clear of the overrun flag
- en_load_out  output  1  load permission to the frontend
- int_out  output  1  host interrupt, "window open"
- overrun_out  output  1  sticky: SPI transfer still active when video resumed
- xfer_cnt_out  output  4  completed transfers in the current/last window, saturating
- frame_cnt_out  output  FRAME_CNT_W  blanking-interval counter

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). Under reset all flops clear and all outputs are 0. State is SCAN and div_cnt is 0.
- cs synchroniser: cs_in passes through a 2-FF synchroniser that resets to 1, giving cs_s. cs_fall and cs_rise are edges of cs_s against its own delayed copy. A pin edge therefore acts 3 cycles later.
- Blank edge: blank_rise = screen_inactive_in & ~prev. blank_fall = ~screen_inactive_in & prev. prev resets to 0.
- Frame counter: frame_cnt increments on every blank_rise and wraps from max to 0.
- Divider on blank_rise:
  - If div_cnt == 0: open the window and load div_cnt <= cfg_div.
  - Otherwise: div_cnt decrements.
  - cfg_div is sampled only at that instant.
- States SCAN, WINDOW, XFER:
  - SCAN -> WINDOW on blank_rise when the divider opens. xfer_cnt clears to 0 in the same edge.
  - WINDOW -> XFER on cs_fall.
  - XFER -> WINDOW on cs_rise. xfer_cnt increments, saturating at 15.
  - WINDOW -> SCAN on blank_fall.
  - XFER -> SCAN on blank_fall. overrun sets to 1 and xfer_cnt is not incremented.
- en_load_out = (state != SCAN) & screen_inactive_in. It is combinational so the load permission drops in the same cycle active video begins.
- int_out (default build): high while state == WINDOW and no cs_fall has occurred since the window opened. It drops on the first cs_fall and on window close.
- Transfer in progress at window open: if cs_s is low when the window opens, the state is WINDOW. XFER is entered only on a subsequent cs_fall. The pre-existing transfer is not counted.
- Simultaneous events:
  - blank_fall and cs_fall in the same cycle: go to SCAN, no overrun.
  - blank_fall and cs_rise in the same cycle in XFER: the transfer counts as completed, go to SCAN, no overrun.
- Overrun flag:
  - clr_ovr clears it.
  - If clr_ovr and an overrun set coincide, set wins.
- Latency: en_load_out and int_out rise 1 cycle after the screen_inactive_in rising edge.
- Reset mid-window: en_load_out drops immediately. The next window opens on the first blank_rise after reset release.

Optional Feature:
- Macro: EMERN_INT_PULSE_EN.
- Defined: int_out becomes a pulse of exactly INT_PULSE_LEN cycles starting at window open. A cs_fall or window close truncates it. int_out never re-asserts within the same window.
- Undefined: level behaviour as above; INT_PULSE_LEN is unused.

Test Plan:
- Reset then screen_inactive 0->1 with cfg_div=0 -> en_load_out=1 and int_out=1 at +1 cycle; frame_cnt_out=1; state WINDOW.
- cfg_div=2, 6 blanking intervals -> window opens on intervals 1 and 4 only; frame_cnt_out=6.
- In window, cs_in low 40 cycles then high, repeated twice, before blank end -> int_out falls 3 cycles after the first cs low; xfer_cnt_out=2; overrun_out=0.
- cs_in low in window, screen_inactive falls while cs low -> en_load_out=0 same cycle; overrun_out=1 sticky; clr_ovr pulse -> 0.
- cs_in already low at window open, then released and re-asserted -> first release not counted; xfer_cnt_out=1 after second transfer.
- EMERN_INT_PULSE_EN defined, INT_PULSE_LEN=4, no SPI activity -> int_out high exactly 4 cycles per window.

Source files
------------

// File: rtl/emern_load_window_ctrl.sv
// rtl/emern_load_window_ctrl.sv - blanking-interval load window scheduler for the SPI register frontend
// Optional build macro: EMERN_INT_PULSE_EN (int_out becomes an INT_PULSE_LEN-cycle pulse at window open)
module emern_load_window_ctrl #(
    parameter int FRAME_CNT_W   = 8,
    parameter int INT_PULSE_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   screen_inactive_in,
    input  logic                   cs_in,
    input  logic [1:0]             cfg_div,
    input  logic                   clr_ovr,
    output logic                   en_load_out,
    output logic                   int_out,
    output logic                   overrun_out,
    output logic [3:0]             xfer_cnt_out,
    output logic [FRAME_CNT_W-1:0] frame_cnt_out
);

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        WINDOW = 2'd1,
        XFER   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   cs_meta_q, cs_meta_d;
    logic                   cs_s_q, cs_s_d;
    logic                   cs_dly_q, cs_dly_d;
    logic                   prev_q, prev_d;
    logic [1:0]             div_cnt_q, div_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]             xfer_cnt_q, xfer_cnt_d;
    logic                   overrun_q, overrun_d;
    logic                   int_q, int_d;
`ifdef EMERN_INT_PULSE_EN
    logic [7:0]             pcnt_q, pcnt_d;
`endif

    logic blank_rise;
    logic blank_fall;
    logic cs_fall;
    logic cs_rise;
    logic win_open;

    // Edge detection on the synchronised chip select and on the blanking input
    always_comb begin
        blank_rise = screen_inactive_in & ~prev_q;
        blank_fall = ~screen_inactive_in & prev_q;
        cs_fall    = ~cs_s_q & cs_dly_q;
        cs_rise    = cs_s_q & ~cs_dly_q;
        win_open   = blank_rise & (div_cnt_q == 2'd0);
    end

    // Next-state logic: synchroniser, counters, divider, window FSM, overrun and interrupt
    always_comb begin
        cs_meta_d   = cs_in;
        cs_s_d      = cs_meta_q;
        cs_dly_d    = cs_s_q;
        prev_d      = screen_inactive_in;
        div_cnt_d   = div_cnt_q;
        frame_cnt_d = frame_cnt_q;
        state_d     = state_q;
        xfer_cnt_d  = xfer_cnt_q;
        overrun_d   = overrun_q;
        int_d       = int_q;
`ifdef EMERN_INT_PULSE_EN
        pcnt_d      = pcnt_q;
`endif

        // cfg_div is only looked at when the divider reloads
        if (blank_rise) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (div_cnt_q == 2'd0) begin
                div_cnt_d = cfg_div;
            end else begin
                div_cnt_d = div_cnt_q - 2'd1;
            end
        end

        // A transfer already in flight at window open is ignored until its cs_rise
        // passes harmlessly in WINDOW; only a fresh cs_fall starts a counted transfer.
        case (state_q)
            SCAN: begin
                if (win_open) begin
                    state_d    = WINDOW;
                    xfer_cnt_d = 4'd0;
                end
            end
            WINDOW: begin
                if (blank_fall) begin
                    state_d = SCAN;
                end else if (cs_fall) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (cs_rise) begin
                    if (xfer_cnt_q != 4'd15) begin
                        xfer_cnt_d = xfer_cnt_q + 4'd1;
                    end
                end
                if (blank_fall) begin
                    state_d = SCAN;
                    if (!cs_rise) begin
                        overrun_d = 1'b1;
                    end
                end else if (cs_rise) begin
                    state_d = WINDOW;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        // Clear yields to a simultaneous overrun set
        if (clr_ovr && !(state_q == XFER && blank_fall && !cs_rise)) begin
            overrun_d = 1'b0;
        end

`ifdef EMERN_INT_PULSE_EN
        if (state_q == SCAN && win_open) begin
            int_d  = 1'b1;
            pcnt_d = 8'(INT_PULSE_LEN - 1);
        end else if (int_q) begin
            if (cs_fall || blank_fall || pcnt_q == 8'd0) begin
                int_d = 1'b0;
            end else begin
                pcnt_d = pcnt_q - 8'd1;
            end
        end
`else
        if (state_q == SCAN && win_open) begin
            int_d = 1'b1;
        end else if (int_q && (cs_fall || blank_fall)) begin
            int_d = 1'b0;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            cs_meta_q   <= 1'b1;
            cs_s_q      <= 1'b1;
            cs_dly_q    <= 1'b1;
            prev_q      <= 1'b0;
            div_cnt_q   <= 2'd0;
            frame_cnt_q <= '0;
            xfer_cnt_q  <= 4'd0;
            overrun_q   <= 1'b0;
            int_q       <= 1'b0;
`ifdef EMERN_INT_PULSE_EN
            pcnt_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cs_meta_q   <= cs_meta_d;
            cs_s_q      <= cs_s_d;
            cs_dly_q    <= cs_dly_d;
            prev_q      <= prev_d;
            div_cnt_q   <= div_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
            overrun_q   <= overrun_d;
            int_q       <= int_d;
`ifdef EMERN_INT_PULSE_EN
            pcnt_q      <= pcnt_d;
`endif
        end
    end

    // Load permission is combinational so it drops in the first active-video cycle
    always_comb begin
        en_load_out   = (state_q != SCAN) & screen_inactive_in;
        int_out       = int_q;
        overrun_out   = overrun_q;
        xfer_cnt_out  = xfer_cnt_q;
        frame_cnt_out = frame_cnt_q;
    end

endmodule

// File: tb/tb_emern_load_window_ctrl.sv
// tb/tb_emern_load_window_ctrl.sv - directed self-checking bench for emern_load_window_ctrl
module tb_emern_load_window_ctrl;

    logic       clk;
    logic       rst_n;
    logic       screen_inactive_in;
    logic       cs_in;
    logic [1:0] cfg_div;
    logic       clr_ovr;
    logic       en_load_out;
    logic       int_out;
    logic       overrun_out;
    logic [3:0] xfer_cnt_out;
    logic [7:0] frame_cnt_out;

    int total;
    int bad;

    emern_load_window_ctrl #(
        .FRAME_CNT_W  (8),
        .INT_PULSE_LEN(4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .screen_inactive_in(screen_inactive_in),
        .cs_in             (cs_in),
        .cfg_div           (cfg_div),
        .clr_ovr           (clr_ovr),
        .en_load_out       (en_load_out),
        .int_out           (int_out),
        .overrun_out       (overrun_out),
        .xfer_cnt_out      (xfer_cnt_out),
        .frame_cnt_out     (frame_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic open_window();
        screen_inactive_in = 1'b0;
        repeat (3) step();
        screen_inactive_in = 1'b1;
        step();
    endtask

    task automatic close_window();
        screen_inactive_in = 1'b0;
        step();
    endtask

    task automatic spi_xfer(input int nlow, input int nhigh);
        cs_in = 1'b0;
        repeat (nlow) step();
        cs_in = 1'b1;
        repeat (nhigh) step();
    endtask

    task automatic blank_interval(output logic w);
        screen_inactive_in = 1'b0;
        repeat (5) step();
        screen_inactive_in = 1'b1;
        step();
        w = en_load_out;
        repeat (10) step();
        screen_inactive_in = 1'b0;
        step();
    endtask

    initial begin
        logic       w;
        logic [2:0] exp_win [6];
        int         int_hi;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        screen_inactive_in = 1'b0;
        cs_in   = 1'b1;
        cfg_div = 2'd0;
        clr_ovr = 1'b0;
        repeat (3) step();

        // reset state
        chk("rst_en_load", en_load_out, 0);
        chk("rst_int", int_out, 0);
        chk("rst_ovr", overrun_out, 0);
        chk("rst_xfer", xfer_cnt_out, 0);
        chk("rst_frame", frame_cnt_out, 0);
        rst_n = 1'b1;
        repeat (3) step();

        // first window with cfg_div=0, one-cycle latency
        screen_inactive_in = 1'b1;
        #1;
        chk("t1_en_load_pre", en_load_out, 0);
        step();
        chk("t1_en_load", en_load_out, 1);
        chk("t1_int", int_out, 1);
        chk("t1_frame", frame_cnt_out, 1);
        repeat (5) step();
        screen_inactive_in = 1'b0;
        #1;
        chk("t1_en_load_drop", en_load_out, 0);
        step();

        // divider cfg_div=2 over 6 blanking intervals
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cfg_div = 2'd2;
        exp_win[0] = 1; exp_win[1] = 0; exp_win[2] = 0;
        exp_win[3] = 1; exp_win[4] = 0; exp_win[5] = 0;
        for (int i = 0; i < 6; i++) begin
            blank_interval(w);
            chk($sformatf("t2_win%0d", i + 1), w, exp_win[i][0]);
        end
        chk("t2_frame", frame_cnt_out, 6);
        cfg_div = 2'd0;

        // two transfers in a window, int falls 3 cycles after cs low
        open_window();
        chk("t3_int_open", int_out, 1);
        cs_in = 1'b0;
        step();
        step();
        chk("t3_int_2cyc", int_out, 1);
        step();
        chk("t3_int_3cyc", int_out, 0);
        repeat (37) step();
        cs_in = 1'b1;
        repeat (40) step();
        spi_xfer(40, 40);
        chk("t3_xfer", xfer_cnt_out, 2);
        chk("t3_ovr", overrun_out, 0);
        chk("t3_int_stay", int_out, 0);
        chk("t3_en_load", en_load_out, 1);
        close_window();
        chk("t3_xfer_hold", xfer_cnt_out, 2);

        // overrun: blanking ends mid-transfer
        open_window();
        chk("t4_xfer_clr", xfer_cnt_out, 0);
        cs_in = 1'b0;
        repeat (10) step();
        screen_inactive_in = 1'b0;
        #1;
        chk("t4_en_load_drop", en_load_out, 0);
        step();
        chk("t4_ovr_set", overrun_out, 1);
        chk("t4_xfer", xfer_cnt_out, 0);
        cs_in = 1'b1;
        repeat (10) step();
        chk("t4_ovr_sticky", overrun_out, 1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("t4_ovr_clr", overrun_out, 0);

        // transfer already in flight at window open is not counted
        cs_in = 1'b0;
        repeat (5) step();
        open_window();
        chk("t5_int_open", int_out, 1);
        cs_in = 1'b1;
        repeat (10) step();
        chk("t5_xfer_pre", xfer_cnt_out, 0);
        chk("t5_int_pre", int_out, 1);
        spi_xfer(20, 20);
        chk("t5_xfer", xfer_cnt_out, 1);
        chk("t5_int", int_out, 0);
        close_window();

        // transfer counter saturates at 15
        open_window();
        for (int i = 0; i < 17; i++) spi_xfer(6, 6);
        chk("t6_xfer_sat", xfer_cnt_out, 15);
        close_window();

        // blank_fall coincident with cs_rise in XFER: counted, no overrun
        open_window();
        cs_in = 1'b0;
        repeat (10) step();
        cs_in = 1'b1;
        step();
        step();
        screen_inactive_in = 1'b0;
        step();
        chk("t7_ovr", overrun_out, 0);
        chk("t7_xfer", xfer_cnt_out, 1);

        // blank_fall coincident with cs_fall in WINDOW: closes, no overrun
        open_window();
        cs_in = 1'b0;
        step();
        step();
        screen_inactive_in = 1'b0;
        step();
        chk("t8_ovr", overrun_out, 0);
        chk("t8_int", int_out, 0);
        cs_in = 1'b1;
        repeat (5) step();
        chk("t8_ovr_after", overrun_out, 0);

        // interrupt high-time over a quiet 30-cycle window
        open_window();
        int_hi = 0;
        for (int i = 0; i < 30; i++) begin
            if (int_out) int_hi++;
            step();
        end
        screen_inactive_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (int_out) int_hi++;
        end
`ifdef EMERN_INT_PULSE_EN
        chk("t9_int_cycles", int_hi, 4);
`else
        chk("t9_int_cycles", int_hi, 30);
`endif

        // reset mid-window drops en_load at once; next window opens on first blank_rise
        open_window();
        chk("t10_en_load", en_load_out, 1);
        rst_n = 1'b0;
        #1;
        chk("t10_en_load_rst", en_load_out, 0);
        chk("t10_frame_rst", frame_cnt_out, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t10_en_load_reopen", en_load_out, 1);
        chk("t10_frame", frame_cnt_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
